// File: rtl/three_bit_reg.sv
// rtl/three_bit_reg.sv - parallel-load register with load enable and synchronous reset
//
// Purpose:
//   WIDTH-bit storage element for register-transfer datapaths. Examples are
//   accumulators and operand latches fed from a shared bus. On each rising
//   CLK edge, Reset has priority over Load. Load captures D. Otherwise the
//   register holds its value.
//
// Ports:
//   CLK    in   1      clock; all state changes on the rising edge
//   Reset  in   1      synchronous reset, active-high
//   D      in   WIDTH  parallel data to load
//   Load   in   1      load enable, active-high
//   Q      out  WIDTH  registered contents, driven directly from flops
module three_bit_reg #(
    parameter int                 WIDTH       = 3,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             Load,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // The next-state mux sees only Load and D. Reset is applied in the flop
    // block so that it overrides a simultaneous load.
    always_comb begin
        q_d = q_q;
        if (Load) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Q comes straight from the flops, so there is no combinational path
    // from D or Load to Q.
    assign Q = q_q;

endmodule

// File: tb/tb_three_bit_reg.sv
// tb/tb_three_bit_reg.sv - scoreboard bench for three_bit_reg (default and wide instances)
module tb_three_bit_reg;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] d8;
    logic [2:0] q3;
    logic [7:0] q8;

    three_bit_reg u_dut3 (
        .CLK   (clk),
        .Reset (rst),
        .D     (d8[2:0]),
        .Load  (load),
        .Q     (q3)
    );

    three_bit_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
        .CLK   (clk),
        .Reset (rst),
        .D     (d8),
        .Load  (load),
        .Q     (q8)
    );

    typedef struct {
        logic [2:0] e3;
        logic [7:0] e8;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] m3;
    logic [7:0] m8;
    bit         stim_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: reset gives the reset value, load takes D,
    // and otherwise the value is unchanged.
    task automatic drive(input bit r, input bit l, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst  = r;
        load = l;
        d8   = d;
        if (r) begin
            m3 = 3'b000;
            m8 = 8'hA5;
        end else if (l) begin
            m3 = d[2:0];
            m8 = d;
        end
        e.e3 = m3;
        e.e8 = m8;
        sb_q.push_back(e);
    endtask

    // The inputs glitch between edges. Load is low again before the rising
    // edge, so the expected value is a hold.
    task automatic drive_glitch(input logic [7:0] d);
        drive(1'b0, 1'b0, d);
        #1 load = 1'b1; d8 = ~d;
        #2 load = 1'b0; d8 = d;
    endtask

    // Monitor: after every rising edge, compare Q with the oldest expectation.
    // Then recheck Q after the falling edge, where it must not change.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("q3_rise", {5'b0, q3}, {5'b0, e.e3});
                check("q8_rise", q8, e.e8);
                @(negedge clk);
                #1;
                check("q3_fall", {5'b0, q3}, {5'b0, e.e3});
                check("q8_fall", q8, e.e8);
            end
        end
    end

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        d8   = 8'h00;
        m3   = 3'b000;
        m8   = 8'h00;

        drive(1'b1, 1'b1, 8'hFF);
        drive(1'b0, 1'b0, 8'h05);
        drive(1'b0, 1'b1, 8'h05);
        repeat (3) drive(1'b0, 1'b0, 8'h02);
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h36);
        drive(1'b0, 1'b1, 8'hE7);
        drive(1'b1, 1'b1, 8'h03);
        drive(1'b0, 1'b1, 8'h03);
        drive_glitch(8'h5A);
        drive_glitch(8'hC4);
        drive(1'b1, 1'b0, 8'h7E);
        repeat (4) drive(1'b0, 1'b0, 8'($urandom));

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                drive_glitch(8'($urandom));
            end else begin
                drive($urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom));
            end
        end

        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 8'(sb_q.size()), 8'd0);
        stim_done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: got running expected finished at %0t", $time);
            $fatal(1, "timeout");
        end
    end

endmodule
